led_matrix_scanner: RTL and testbench
=====================================

// Module: led_matrix_scanner
// PURPOSE
//  Time-multiplexed row scanner for a bicolour (red/green) LED dot matrix, generalised in rows/cols.
//  Holds two full frame buffers (front = displayed, back = written by the host FSM, e.g. lock/unlock glyphs).
//  Swaps buffers on request at a frame boundary only (tear-free). Adds whole-display blink and enable/blank.
//  Sits between the safe-box control FSM and the matrix pins.
// PARAMETERS
//  ROWS            8     number of matrix rows scanned (>=2)
//  COLS            8     columns per row, per colour
//  SCAN_DIV        5000  clk cycles each row is held (>=2)
//  BLINK_DIV       50    full frames per blink half-period (>=1)
//  ROW_ACTIVE_LOW  1     1: selected row driven 0, others 1; 0: inverted
// PORTS
//  clk         in   1                   system clock
//  rst         in   1                   synchronous reset, active-high
//  enable      in   1                   0: display blanked, scan counters held at 0
//  blink_en    in   1                   1: columns blanked during odd blink phase
//  wr_en       in   1                   write one row of the back buffer (qualified by wr_ready)
//  wr_row      in   $clog2(ROWS)        back-buffer row address
//  wr_red      in   COLS                red column bits for wr_row (1 = LED on)
//  wr_grn      in   COLS                green column bits for wr_row
//  wr_ready    out  1                   1 when writes and swap_req are accepted
//  swap_req    in   1                   request front/back exchange at next frame end
//  swap_done   out  1                   one-cycle pulse in the cycle the exchange occurs
//  frame_start out  1                   one-cycle pulse when row index wraps to 0
//  row         out  ROWS                row select, one-hot in active polarity
//  col_r       out  COLS                red column drive (1 = on)
//  col_g       out  COLS                green column drive (1 = on)
// BEHAVIOUR
//  Reset: div_cnt=0, row_idx=0, blink_cnt=0, blink_phase=0, front_sel=0, swap_pend=0, both buffers cleared;
//   row = all inactive, col_r=col_g=0, wr_ready=1, swap_done=0, frame_start=0.
//  Divider: div_cnt counts 0..SCAN_DIV-1 while enable; tick = (div_cnt==SCAN_DIV-1); div_cnt wraps to 0 on tick.
//  Row index: on tick, row_idx<=row_idx+1, wraps ROWS-1 -> 0 (no out-of-range state for non-power-of-2 ROWS).
//  frame_start: pulses in the cycle row_idx changes ROWS-1 -> 0.
//  Outputs registered: row/col_r/col_g reflect row_idx and front buffer one cycle after row_idx changes
//   (1-cycle latency); first row 0 appears the cycle after rst deasserts with enable=1.
//  Blink: blink_cnt counts frame wraps 0..BLINK_DIV-1; at wrap blink_phase toggles. If blink_en && blink_phase,
//   col_r=col_g=0 while row keeps scanning. blink_en=0 does not stop blink_cnt.
//  enable=0: next cycle row=all inactive, cols=0; div_cnt, row_idx, blink_cnt, blink_phase forced to 0.
//   Buffers, front_sel, swap_pend and the write path remain operational.
//  Write: wr_en && wr_ready writes {wr_red,wr_grn} to back[wr_row] at the clock edge. wr_en with wr_ready=0
//   is dropped. wr_row >= ROWS ignored. Front buffer never written directly.
//  Swap FSM: IDLE --(swap_req && wr_ready)--> PEND (wr_ready=0) --(tick && row_idx==ROWS-1)--> IDLE:
//   front_sel toggles, swap_done pulses, wr_ready=1 next cycle. The new front is displayed from row 0 onward.
//  swap_req in PEND ignored (no queueing). swap_req and wr_en in the same IDLE cycle: write lands in the old
//   back buffer, which becomes the new front at the swap.
//  enable=0 while PEND: swap completes on the next cycle (no frame in progress); swap_done still pulses once.
//  rst mid-PEND or mid-frame: everything returns to reset values in one cycle; pending swap discarded.
//  Back buffer after a swap holds the previous front content (true exchange, no copy).
// TESTING (SCAN_DIV=4, ROWS=8, COLS=8, BLINK_DIV=2, ROW_ACTIVE_LOW=1)
//  1 Reset then enable=1, all buffers 0 -> row steps 8'hFE,8'hFD,...,8'h7F each 4 cycles, cols 0, frame_start every 32.
//  2 Write back rows 0..7 with red=8'h81,8'h42,8'h24,8'h18,8'h18,8'h24,8'h42,8'h81, swap_req -> wr_ready low until
//    frame end, swap_done single pulse with frame_start, next frame col_r shows the X pattern per row.
//  3 swap_req + wr_en(row3, grn=8'hFF) same cycle, then wr_en(row4) while PEND -> row3 green shown, row4 write dropped.
//  4 blink_en=1 with X displayed -> cols alternate 2 frames shown / 2 frames zero; row never stops scanning.
//  5 enable=0 mid-row 5 -> next cycle row=8'hFF, cols 0; enable=1 -> scan restarts at row 0 after 1 cycle.
//  6 rst asserted while PEND -> outputs blanked, wr_ready=1, no swap_done, front shows cleared buffer.

Source files
------------

// File: rtl/led_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module      : led_matrix_scanner
// Description : Row-multiplexed bicolour LED matrix driver with double-buffered
//               frames, tear-free swap at frame end, blink and enable/blank.
// Revision    : 1.0  initial release
// ============================================================================
module led_matrix_scanner #(
    parameter int ROWS           = 8,
    parameter int COLS           = 8,
    parameter int SCAN_DIV       = 5000,
    parameter int BLINK_DIV      = 50,
    parameter bit ROW_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    blink_en,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_red,
    input  logic [COLS-1:0]         wr_grn,
    output logic                    wr_ready,
    input  logic                    swap_req,
    output logic                    swap_done,
    output logic                    frame_start,
    output logic [ROWS-1:0]         row,
    output logic [COLS-1:0]         col_r,
    output logic [COLS-1:0]         col_g
);

    localparam int c_RW = $clog2(ROWS);
    localparam int c_DW = $clog2(SCAN_DIV);
    localparam int c_BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [c_DW-1:0] c_DIV_LAST   = c_DW'(SCAN_DIV - 1);
    localparam logic [c_RW-1:0] c_ROW_LAST   = c_RW'(ROWS - 1);
    localparam logic [c_BW-1:0] c_BLINK_LAST = c_BW'(BLINK_DIV - 1);
    localparam logic [ROWS-1:0] c_ROW_IDLE   = ROW_ACTIVE_LOW ? {ROWS{1'b1}} : {ROWS{1'b0}};

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_PEND = 1'b1;

    logic [c_DW-1:0] r_div_cnt;
    logic [c_RW-1:0] r_row_idx;
    logic [c_BW-1:0] r_blink_cnt;
    logic            r_blink_phase;
    logic            r_front_sel;
    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic            w_swap;
    logic            r_swap_done;
    logic            r_frame_start;
    logic [ROWS-1:0] r_row;
    logic [COLS-1:0] r_col_r;
    logic [COLS-1:0] r_col_g;

    logic [COLS-1:0] r_buf_r [2][ROWS];
    logic [COLS-1:0] r_buf_g [2][ROWS];

    logic            w_tick;
    logic            w_frame_end;
    logic            w_back;
    logic            w_wr;
    logic [ROWS-1:0] w_onehot;

    assign w_tick      = enable && (r_div_cnt == c_DIV_LAST);
    assign w_frame_end = w_tick && (r_row_idx == c_ROW_LAST);
    assign w_back      = ~r_front_sel;
    assign wr_ready    = (r_state == c_ST_IDLE);
    assign w_wr        = wr_en && wr_ready && (wr_row <= c_ROW_LAST);
    assign w_onehot    = {{(ROWS-1){1'b0}}, 1'b1} << r_row_idx;

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_div_cnt     <= '0;
            r_row_idx     <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            if (w_tick) begin
                r_div_cnt <= '0;
                r_row_idx <= (r_row_idx == c_ROW_LAST) ? '0 : r_row_idx + 1'b1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
            if (w_frame_end) begin
                if (r_blink_cnt == c_BLINK_LAST) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < ROWS; i++) begin
                    r_buf_r[b][i] <= '0;
                    r_buf_g[b][i] <= '0;
                end
            end
        end else if (w_wr) begin
            r_buf_r[w_back][wr_row] <= wr_red;
            r_buf_g[w_back][wr_row] <= wr_grn;
        end
    end

    // With the display disabled no frame is in progress, so a pending swap may complete at once.
    always_comb begin
        w_state_nxt = r_state;
        w_swap      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (swap_req) begin
                    w_state_nxt = c_ST_PEND;
                end
            end
            c_ST_PEND: begin
                if (!enable || w_frame_end) begin
                    w_swap      = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_front_sel <= 1'b0;
            r_swap_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_swap_done <= w_swap;
            if (w_swap) begin
                r_front_sel <= ~r_front_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_row         <= c_ROW_IDLE;
            r_col_r       <= '0;
            r_col_g       <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_row         <= ROW_ACTIVE_LOW ? ~w_onehot : w_onehot;
            r_frame_start <= w_frame_end;
            if (blink_en && r_blink_phase) begin
                r_col_r <= '0;
                r_col_g <= '0;
            end else begin
                r_col_r <= r_buf_r[r_front_sel][r_row_idx];
                r_col_g <= r_buf_g[r_front_sel][r_row_idx];
            end
        end
    end

    assign swap_done   = r_swap_done;
    assign frame_start = r_frame_start;
    assign row         = r_row;
    assign col_r       = r_col_r;
    assign col_g       = r_col_g;

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_matrix_scanner
// Description : Directed self-checking bench for led_matrix_scanner.
// Revision    : 1.0  initial release
// ============================================================================
module tb_led_matrix_scanner;

    localparam int ROWS      = 8;
    localparam int COLS      = 8;
    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic            blink_en;
    logic            wr_en;
    logic [2:0]      wr_row;
    logic [COLS-1:0] wr_red;
    logic [COLS-1:0] wr_grn;
    logic            wr_ready;
    logic            swap_req;
    logic            swap_done;
    logic            frame_start;
    logic [ROWS-1:0] row;
    logic [COLS-1:0] col_r;
    logic [COLS-1:0] col_g;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] x_pat;
    logic [63:0] g3_pat;
    logic [7:0]  exp_row;

    led_matrix_scanner #(
        .ROWS           (ROWS),
        .COLS           (COLS),
        .SCAN_DIV       (SCAN_DIV),
        .BLINK_DIV      (BLINK_DIV),
        .ROW_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .blink_en    (blink_en),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_red      (wr_red),
        .wr_grn      (wr_grn),
        .wr_ready    (wr_ready),
        .swap_req    (swap_req),
        .swap_done   (swap_done),
        .frame_start (frame_start),
        .row         (row),
        .col_r       (col_r),
        .col_g       (col_g)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full frame from the first cycle of row 0; checks each row's first cycle.
    task automatic run_frame(input string tag, input logic [63:0] er, input logic [63:0] eg);
        for (int k = 0; k < ROWS; k++) begin
            step();
            exp_row = ~(8'h01 << k);
            check($sformatf("%s row%0d sel", tag, k), row, exp_row);
            check($sformatf("%s row%0d col_r", tag, k), col_r, er[8*k +: 8]);
            check($sformatf("%s row%0d col_g", tag, k), col_g, eg[8*k +: 8]);
            check($sformatf("%s row%0d swap_done", tag, k), swap_done, 0);
            repeat (SCAN_DIV - 1) step();
        end
        check({tag, " frame_start"}, frame_start, 1);
    endtask

    task automatic wait_swap(input string tag, input int exp_n);
        int n;
        n = 0;
        while (swap_done !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check({tag, " swap_done seen"}, swap_done, 1);
        check({tag, " swap latency"}, 64'(n), 64'(exp_n));
        check({tag, " frame_start with swap"}, frame_start, 1);
        check({tag, " wr_ready after swap"}, wr_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        x_pat    = 64'h8142_2418_1824_4281;
        g3_pat   = 64'h0000_0000_FF00_0000;
        rst      = 1'b1;
        enable   = 1'b0;
        blink_en = 1'b0;
        wr_en    = 1'b0;
        wr_row   = '0;
        wr_red   = '0;
        wr_grn   = '0;
        swap_req = 1'b0;
        repeat (3) step();
        check("reset row", row, 8'hFF);
        check("reset col_r", col_r, 0);
        check("reset col_g", col_g, 0);
        check("reset wr_ready", wr_ready, 1);
        check("reset swap_done", swap_done, 0);
        check("reset frame_start", frame_start, 0);

        // Plain scan over empty buffers
        rst    = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < ROWS; k++) begin
            for (int j = 0; j < SCAN_DIV; j++) begin
                step();
                exp_row = ~(8'h01 << k);
                check($sformatf("t1 row%0d.%0d sel", k, j), row, exp_row);
                check($sformatf("t1 row%0d.%0d frame_start", k, j), frame_start,
                      64'((k == ROWS - 1) && (j == SCAN_DIV - 1)));
                check($sformatf("t1 row%0d.%0d cols", k, j), {col_r, col_g}, 0);
            end
        end

        // Load the X glyph into the back buffer and swap
        for (int i = 0; i < ROWS; i++) begin
            wr_en  = 1'b1;
            wr_row = 3'(i);
            wr_red = x_pat[8*i +: 8];
            wr_grn = 8'h00;
            step();
        end
        wr_en    = 1'b0;
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        check("t2 wr_ready pending", wr_ready, 0);
        check("t2 no early swap_done", swap_done, 0);
        wait_swap("t2", 23);
        run_frame("t2 X", x_pat, 64'h0);

        // Same-cycle write+swap lands; write while pending is dropped
        swap_req = 1'b1;
        wr_en    = 1'b1;
        wr_row   = 3'd3;
        wr_red   = 8'h00;
        wr_grn   = 8'hFF;
        step();
        check("t3 wr_ready pending", wr_ready, 0);
        wr_row = 3'd4;
        wr_red = 8'hFF;
        wr_grn = 8'hFF;
        step();
        wr_en    = 1'b0;
        swap_req = 1'b0;
        wait_swap("t3", 30);
        run_frame("t3 g3", 64'h0, g3_pat);

        // Blink: X back in front, two frames dark then two shown
        blink_en = 1'b1;
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        wait_swap("t4", 31);
        run_frame("t4 blank0", 64'h0, 64'h0);
        run_frame("t4 blank1", 64'h0, 64'h0);
        run_frame("t4 show0", x_pat, 64'h0);
        run_frame("t4 show1", x_pat, 64'h0);
        blink_en = 1'b0;

        // Disable mid-row 5, then re-enable
        repeat (22) step();
        check("t5 row5 sel", row, 8'hDF);
        check("t5 row5 col_r", col_r, 8'h24);
        enable = 1'b0;
        step();
        check("t5 off row", row, 8'hFF);
        check("t5 off cols", {col_r, col_g}, 0);
        step();
        check("t5 off row hold", row, 8'hFF);
        check("t5 off frame_start", frame_start, 0);
        enable = 1'b1;
        step();
        check("t5 restart row0", row, 8'hFE);
        check("t5 restart col_r", col_r, 8'h81);
        repeat (3) step();
        check("t5 row0 held", row, 8'hFE);
        step();
        check("t5 row1", row, 8'hFD);
        check("t5 row1 col_r", col_r, 8'h42);

        // Reset while a swap is pending
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        check("t6 wr_ready pending", wr_ready, 0);
        repeat (2) step();
        rst = 1'b1;
        step();
        check("t6 rst row", row, 8'hFF);
        check("t6 rst cols", {col_r, col_g}, 0);
        check("t6 rst wr_ready", wr_ready, 1);
        check("t6 rst swap_done", swap_done, 0);
        check("t6 rst frame_start", frame_start, 0);
        rst = 1'b0;
        run_frame("t6 cleared", 64'h0, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
